// File: rtl/s_word_seq.sv
// -----------------------------------------------------------------------------
// s_word_seq -- SPC700 16-bit word instruction sequencer
//
// Runs ADDW, SUBW, CMPW, INCW and DECW through the shared 8-bit ALU in two
// passes. The LO pass computes the low byte. The HI pass computes the high
// byte, with the low-byte carry chained in. The block merges the per-byte
// flags into word flags and reports result, flags and write-enables with a
// one-cycle done pulse. While alu_own is high, the core's ALU operand mux
// selects this block.
//
// Configuration macro:
//   S_WORD_SEQ_CMPW_EN  defined   : op 2 performs CMPW (flags N,Z,C; no write).
//                       undefined : op 2 is treated as an illegal op.
//
// Ports:
//   clk, n_rst       clock, synchronous active-low reset
//   start            request, sampled only in IDLE
//   op[2:0]          0 ADDW, 1 SUBW, 2 CMPW, 3 INCW, 4 DECW, 5-7 illegal
//   opa, opb [15:0]  operands (opb ignored for INCW/DECW)
//   busy             high during the LO and HI passes
//   done             one-cycle completion pulse
//   result[15:0]     word result, valid with done
//   result_we        result must be written back, valid with done
//   flgs[4:0]        word flags, indexed AN/AV/AH/AZ/AC
//   flgs_we[4:0]     per-flag update mask, same indexing
//   alu_own          this block drives the ALU this cycle
//   alu_a, alu_b     ALU operands (upper byte always 0)
//   alu_c            ALU carry in
//   alu_control      ALU function select
//   alu_bit8         8-bit ALU mode, always 1
//   alu_y, alu_flgs  ALU outputs (combinational, same cycle)
// -----------------------------------------------------------------------------

package s_cpu_pkg;

    // Flag bit positions in the 5-bit flag vectors.
    localparam int AC = 0;
    localparam int AZ = 1;
    localparam int AH = 2;
    localparam int AV = 3;
    localparam int AN = 4;

    typedef enum logic [3:0] {
        SC_ACTL_OR,
        SC_ACTL_AND,
        SC_ACTL_EOR,
        SC_ACTL_ADD,
        SC_ACTL_SUB,
        SC_ACTL_ADC,
        SC_ACTL_SBC
    } alu_control_type;

endpackage

module s_word_seq
    import s_cpu_pkg::*;
(
    input  logic            clk,
    input  logic            n_rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [15:0]     opa,
    input  logic [15:0]     opb,
    output logic            busy,
    output logic            done,
    output logic [15:0]     result,
    output logic            result_we,
    output logic [4:0]      flgs,
    output logic [4:0]      flgs_we,
    output logic            alu_own,
    output logic [15:0]     alu_a,
    output logic [15:0]     alu_b,
    output logic            alu_c,
    output alu_control_type alu_control,
    output logic            alu_bit8,
    input  logic [15:0]     alu_y,
    input  logic [4:0]      alu_flgs
);

    localparam logic [2:0] OP_ADDW = 3'd0;
    localparam logic [2:0] OP_SUBW = 3'd1;
    localparam logic [2:0] OP_CMPW = 3'd2;
    localparam logic [2:0] OP_INCW = 3'd3;
    localparam logic [2:0] OP_DECW = 3'd4;

    localparam logic [4:0] MASK_ALL = 5'b11111;
    localparam logic [4:0] MASK_NZ  = 5'((1 << AN) | (1 << AZ));
`ifdef S_WORD_SEQ_CMPW_EN
    localparam logic [4:0] MASK_NZC = 5'((1 << AN) | (1 << AZ) | (1 << AC));
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [7:0]  lo_byte_q, lo_byte_d;
    logic        lo_c_q, lo_c_d;
    logic        lo_z_q, lo_z_d;
    logic [15:0] result_q, result_d;
    logic [4:0]  flgs_q, flgs_d;
    logic [4:0]  flgs_we_q, flgs_we_d;
    logic        result_we_q, result_we_d;

    logic        is_sub;
    logic        is_unary;
    logic [4:0]  op_flgs_we;
    logic        op_result_we;

    // The ALU works in 8-bit mode, so the upper result byte carries nothing.
    logic unused_alu_hi;
    assign unused_alu_hi = ^alu_y[15:8];

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples its _d value from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            lo_byte_q   <= '0;
            lo_c_q      <= 1'b0;
            lo_z_q      <= 1'b0;
            result_q    <= '0;
            flgs_q      <= '0;
            flgs_we_q   <= '0;
            result_we_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            lo_byte_q   <= lo_byte_d;
            lo_c_q      <= lo_c_d;
            lo_z_q      <= lo_z_d;
            result_q    <= result_d;
            flgs_q      <= flgs_d;
            flgs_we_q   <= flgs_we_d;
            result_we_q <= result_we_d;
        end
    end

    // SUBW, CMPW and DECW subtract. Carry here means "no borrow", so the LO
    // pass uses SUB (carry-in forced to 1) and the HI pass chains the LO carry.
    // Illegal ops run harmless ADD passes and write nothing back.
    always_comb begin
        is_sub   = op_q inside {OP_SUBW, OP_CMPW, OP_DECW};
        is_unary = op_q inside {OP_INCW, OP_DECW};
    end

    // Write-enable masks for the operation being completed.
    always_comb begin
        op_flgs_we   = '0;
        op_result_we = 1'b0;
        case (op_q)
            OP_ADDW, OP_SUBW: begin
                op_flgs_we   = MASK_ALL;
                op_result_we = 1'b1;
            end
`ifdef S_WORD_SEQ_CMPW_EN
            OP_CMPW: begin
                op_flgs_we   = MASK_NZC;
                op_result_we = 1'b0;
            end
`endif
            OP_INCW, OP_DECW: begin
                op_flgs_we   = MASK_NZ;
                op_result_we = 1'b1;
            end
            default: begin
                op_flgs_we   = '0;
                op_result_we = 1'b0;
            end
        endcase
    end

    // NOTE: every signal driven here gets a default first. Otherwise a path
    // that does not assign a signal would infer a latch.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        lo_byte_d   = lo_byte_q;
        lo_c_d      = lo_c_q;
        lo_z_d      = lo_z_q;
        result_d    = result_q;
        flgs_d      = flgs_q;
        flgs_we_d   = flgs_we_q;
        result_we_d = result_we_q;
        alu_own     = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_c       = 1'b0;
        alu_control = SC_ACTL_OR;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LO;
                    op_d    = op;
                    opa_d   = opa;
                    opb_d   = opb;
                end
            end

            ST_LO: begin
                alu_own     = 1'b1;
                alu_a       = {8'h00, opa_q[7:0]};
                alu_b       = {8'h00, is_unary ? 8'h01 : opb_q[7:0]};
                alu_control = is_sub ? SC_ACTL_SUB : SC_ACTL_ADD;
                lo_byte_d   = alu_y[7:0];
                lo_c_d      = alu_flgs[AC];
                lo_z_d      = alu_flgs[AZ];
                state_d     = ST_HI;
            end

            ST_HI: begin
                alu_own     = 1'b1;
                alu_a       = {8'h00, opa_q[15:8]};
                alu_b       = {8'h00, is_unary ? 8'h00 : opb_q[15:8]};
                alu_c       = lo_c_q;
                alu_control = is_sub ? SC_ACTL_SBC : SC_ACTL_ADC;
                result_d    = {alu_y[7:0], lo_byte_q};
                // The word is zero only if both bytes are zero.
                flgs_d      = alu_flgs;
                flgs_d[AZ]  = lo_z_q & alu_flgs[AZ];
                flgs_we_d   = op_flgs_we;
                result_we_d = op_result_we;
                state_d     = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q == ST_LO) || (state_q == ST_HI);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign result_we = result_we_q;
    assign flgs      = flgs_q;
    assign flgs_we   = flgs_we_q;
    assign alu_bit8  = 1'b1;

endmodule

// File: tb/tb_s_word_seq.sv
// -----------------------------------------------------------------------------
// tb_s_word_seq -- scoreboard bench for s_word_seq
//
// A behavioural 8-bit ALU model answers the sequencer's ALU requests. Stimulus
// pushes hand-computed expectations into a queue. A monitor pops and compares
// them on every done pulse, and also checks that done arrives in the right
// cycle. Flag vectors are written {N,V,H,Z,C}.
// -----------------------------------------------------------------------------

module tb_s_word_seq;
    import s_cpu_pkg::*;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            start;
    logic [2:0]      op;
    logic [15:0]     opa, opb;
    logic            busy, done;
    logic [15:0]     result;
    logic            result_we;
    logic [4:0]      flgs, flgs_we;
    logic            alu_own;
    logic [15:0]     alu_a, alu_b;
    logic            alu_c;
    alu_control_type alu_control;
    logic            alu_bit8;
    logic [15:0]     alu_y;
    logic [4:0]      alu_flgs;

    s_word_seq dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .op         (op),
        .opa        (opa),
        .opb        (opb),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .result_we  (result_we),
        .flgs       (flgs),
        .flgs_we    (flgs_we),
        .alu_own    (alu_own),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_control(alu_control),
        .alu_bit8   (alu_bit8),
        .alu_y      (alu_y),
        .alu_flgs   (alu_flgs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- ALU model (8-bit mode) ----------------
    logic [7:0] m_a, m_b;
    logic       m_cin;
    logic [8:0] m_sum;
    logic [4:0] m_half;

    always_comb begin
        m_a    = alu_a[7:0];
        m_b    = (alu_control == SC_ACTL_SUB || alu_control == SC_ACTL_SBC) ? ~alu_b[7:0] : alu_b[7:0];
        m_cin  = (alu_control == SC_ACTL_SUB) ? 1'b1 :
                 (alu_control == SC_ACTL_ADC || alu_control == SC_ACTL_SBC) ? alu_c : 1'b0;
        m_sum  = {1'b0, m_a} + {1'b0, m_b} + 9'(m_cin);
        m_half = {1'b0, m_a[3:0]} + {1'b0, m_b[3:0]} + 5'(m_cin);
        alu_flgs = '0;
        if (alu_control == SC_ACTL_OR) begin
            alu_y        = {8'h00, alu_a[7:0] | alu_b[7:0]};
            alu_flgs[AN] = alu_y[7];
            alu_flgs[AZ] = (alu_y[7:0] == 8'h00);
        end else begin
            alu_y        = {8'h00, m_sum[7:0]};
            alu_flgs[AN] = m_sum[7];
            alu_flgs[AZ] = (m_sum[7:0] == 8'h00);
            alu_flgs[AC] = m_sum[8];
            alu_flgs[AH] = m_half[4];
            alu_flgs[AV] = (m_a[7] == m_b[7]) && (m_sum[7] != m_a[7]);
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    typedef struct {
        string       name;
        int          done_cyc;
        logic [15:0] result;
        logic [4:0]  flgs;
        logic [4:0]  flgs_we;
        logic        result_we;
        bit          chk_res;
        bit          chk_flgs;
    } exp_t;

    exp_t sb[$];

    // Monitor: compares every done pulse against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_done_cycle"}, cyc, e.done_cyc);
                    check({e.name, "_flgs_we"}, 32'(flgs_we), 32'(e.flgs_we));
                    check({e.name, "_result_we"}, 32'(result_we), 32'(e.result_we));
                    if (e.chk_res)  check({e.name, "_result"}, 32'(result), 32'(e.result));
                    if (e.chk_flgs) check({e.name, "_flgs"}, 32'(flgs), 32'(e.flgs));
                end
            end
        end
    end

    task automatic push_exp(input string nm, input int dcyc, input logic [15:0] res,
                            input logic [4:0] fl, input logic [4:0] we, input logic rwe,
                            input bit cr, input bit cf);
        exp_t e;
        e.name = nm; e.done_cyc = dcyc; e.result = res; e.flgs = fl;
        e.flgs_we = we; e.result_we = rwe; e.chk_res = cr; e.chk_flgs = cf;
        sb.push_back(e);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    task automatic run_op(input string nm, input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] res, input logic [4:0] fl,
                          input logic [4:0] we, input logic rwe, input bit cr, input bit cf);
        push_exp(nm, cyc + 3, res, fl, we, rwe, cr, cf);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},      32'(busy),        32'd0);
        check({tag, "_done"},      32'(done),        32'd0);
        check({tag, "_result"},    32'(result),      32'd0);
        check({tag, "_result_we"}, 32'(result_we),   32'd0);
        check({tag, "_flgs"},      32'(flgs),        32'd0);
        check({tag, "_flgs_we"},   32'(flgs_we),     32'd0);
        check({tag, "_alu_own"},   32'(alu_own),     32'd0);
        check({tag, "_alu_a"},     32'(alu_a),       32'd0);
        check({tag, "_alu_b"},     32'(alu_b),       32'd0);
        check({tag, "_alu_c"},     32'(alu_c),       32'd0);
        check({tag, "_alu_ctl"},   32'(alu_control), 32'(SC_ACTL_OR));
        check({tag, "_alu_bit8"},  32'(alu_bit8),    32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int own_cnt;
        n_rst = 1'b0; start = 1'b0; op = '0; opa = '0; opb = '0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        n_rst = 1'b1;
        @(negedge clk);

        // ADDW 0x0FFF + 0x0001, probing the ALU drive of both passes.
        push_exp("addw_0fff", cyc + 3, 16'h1000, 5'b00100, 5'b11111, 1'b1, 1, 1);
        start = 1'b1; op = 3'd0; opa = 16'h0FFF; opb = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("lo_busy",    32'(busy),        32'd1);
        check("lo_alu_own", 32'(alu_own),     32'd1);
        check("lo_alu_a",   32'(alu_a),       32'h00FF);
        check("lo_alu_b",   32'(alu_b),       32'h0001);
        check("lo_alu_ctl", 32'(alu_control), 32'(SC_ACTL_ADD));
        @(negedge clk);
        check("hi_alu_own", 32'(alu_own),     32'd1);
        check("hi_alu_a",   32'(alu_a),       32'h000F);
        check("hi_alu_b",   32'(alu_b),       32'h0000);
        check("hi_alu_c",   32'(alu_c),       32'd1);
        check("hi_alu_ctl", 32'(alu_control), 32'(SC_ACTL_ADC));
        @(negedge clk);
        check("done_busy",    32'(busy),        32'd0);
        check("done_alu_own", 32'(alu_own),     32'd0);
        check("done_alu_ctl", 32'(alu_control), 32'(SC_ACTL_OR));
        @(negedge clk);

        run_op("addw_7fff", 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 5'b11100, 5'b11111, 1'b1, 1, 1);
        run_op("subw_0_1",  3'd1, 16'h0000, 16'h0001, 16'hFFFF, 5'b10000, 5'b11111, 1'b1, 1, 1);
`ifdef S_WORD_SEQ_CMPW_EN
        run_op("cmpw_eq",   3'd2, 16'h1234, 16'h1234, 16'h0000, 5'b00111, 5'b10011, 1'b0, 0, 1);
`else
        run_op("cmpw_off",  3'd2, 16'h1234, 16'h1234, 16'h0000, 5'b00000, 5'b00000, 1'b0, 0, 0);
`endif
        run_op("incw_ffff", 3'd3, 16'hFFFF, 16'hABCD, 16'h0000, 5'b00111, 5'b10010, 1'b1, 1, 1);
        run_op("decw_0001", 3'd4, 16'h0001, 16'hABCD, 16'h0000, 5'b00111, 5'b10010, 1'b1, 1, 1);
        run_op("addw_z_hi", 3'd0, 16'h0100, 16'h0000, 16'h0100, 5'b00000, 5'b11111, 1'b1, 1, 1);
        run_op("illegal_5", 3'd5, 16'h1111, 16'h2222, 16'h0000, 5'b00000, 5'b00000, 1'b0, 0, 0);
        run_op("illegal_7", 3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 5'b00000, 5'b00000, 1'b0, 0, 0);

        // start held high: one accept every 4 cycles, ALU owned 2 of every 4.
        k = cyc;
        push_exp("held_0", k + 3,  16'h1000, 5'b00100, 5'b11111, 1'b1, 1, 1);
        push_exp("held_1", k + 7,  16'h1000, 5'b00100, 5'b11111, 1'b1, 1, 1);
        push_exp("held_2", k + 11, 16'h1000, 5'b00100, 5'b11111, 1'b1, 1, 1);
        start = 1'b1; op = 3'd0; opa = 16'h0FFF; opb = 16'h0001;
        own_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (alu_own) own_cnt++;
            if (i == 9) start = 1'b0;
        end
        check("held_alu_own_cycles", own_cnt, 6);

        // start kept high through LO/HI/DONE with different operands: ignored.
        push_exp("incw_00ff", cyc + 3, 16'h0100, 5'b00000, 5'b10010, 1'b1, 1, 1);
        start = 1'b1; op = 3'd3; opa = 16'h00FF; opb = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        op = 3'd0; opa = 16'h1111; opb = 16'h1111;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);

        // Reset asserted during HI aborts the op with no done.
        start = 1'b1; op = 3'd0; opa = 16'h0FFF; opb = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_pre_busy", 32'(busy), 32'd1);
        n_rst = 1'b0;
        @(negedge clk);
        check_idle_zero("rst_hi");
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        run_op("after_rst", 3'd0, 16'h0100, 16'h0000, 16'h0100, 5'b00000, 5'b11111, 1'b1, 1, 1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
